// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
//
// Sequencing front end for the 8-bit combinational ALU. Accepts accumulator
// style commands on a valid/ready handshake, drives the ALU operand/select
// inputs from registers, captures the ALU result and flags into an
// accumulator, and returns accumulator + flags on a second valid/ready
// handshake.
//
// Optional feature macro: ALU_SEQ_ADC_EN
//   defined   : op 1000 is add-with-carry (ACC + B + C), done as two ALU ADD
//               passes through the extra EXEC2 state.
//   undefined : op 1000 is forwarded to the ALU like any other select.
//
// Ports
//   clk           in   clock, all state changes on the rising edge
//   rst           in   synchronous active-high reset
//   cmd_valid     in   command present
//   cmd_ready     out  block can accept a command (IDLE only)
//   cmd_op[3:0]   in   operation (1111 = LOAD, otherwise ALU select)
//   cmd_data[7:0] in   immediate operand B / LOAD value
//   rsp_valid     out  response present (RESP state)
//   rsp_ready     in   consumer accepts response
//   rsp_acc[7:0]  out  accumulator register
//   rsp_flags[2:0]out  {carry, zero, overflow} registers
//   alu_a[7:0]    out  ALU operand A (registered)
//   alu_b[7:0]    out  ALU operand B (registered)
//   alu_sel[3:0]  out  ALU select (registered)
//   alu_y[7:0]    in   ALU result
//   alu_carry     in   ALU carry / borrow
//   alu_zero      in   ALU zero flag (ignored, zero is derived from alu_y)
//   alu_overflow  in   ALU signed overflow flag
// -----------------------------------------------------------------------------
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_acc,
  output logic [2:0] rsp_flags,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_y,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_overflow
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_LOAD = 4'b1111;
`ifdef ALU_SEQ_ADC_EN
  localparam logic [3:0] OP_ADC  = 4'b1000;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_EXEC2 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_acc;
  logic       r_c;
  logic       r_z;
  logic       r_v;
  logic [7:0] r_alu_a;
  logic [7:0] r_alu_b;
  logic [3:0] r_alu_sel;
  logic       r_cmd_ready;
  logic       r_rsp_valid;

  // The zero flag is always recomputed from the captured result so that it
  // matches the accumulator even for LOAD and the two-pass ADC.
  logic w_unused_alu_zero;
  assign w_unused_alu_zero = alu_zero;

  logic w_y_zero;
  assign w_y_zero = (alu_y == 8'h00);

`ifdef ALU_SEQ_ADC_EN
  // ADC bookkeeping: the second pass overwrites alu_a/alu_b, so the original
  // operands are kept to derive overflow of the full A + B + C sum.
  logic       r_is_adc;
  logic [7:0] r_orig_a;
  logic [7:0] r_orig_b;
  logic       r_c1;
  logic       w_adc_v;

  assign w_adc_v = (~r_orig_a[7] & ~r_orig_b[7] &  alu_y[7]) |
                   ( r_orig_a[7] &  r_orig_b[7] & ~alu_y[7]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= 8'h00;
      r_c         <= 1'b0;
      r_z         <= 1'b0;
      r_v         <= 1'b0;
      r_alu_a     <= 8'h00;
      r_alu_b     <= 8'h00;
      r_alu_sel   <= 4'h0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
`ifdef ALU_SEQ_ADC_EN
      r_is_adc    <= 1'b0;
      r_orig_a    <= 8'h00;
      r_orig_b    <= 8'h00;
      r_c1        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // Ready comes up one cycle after reset release and stays up while
          // idle; it drops on the accepting edge.
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            if (cmd_op == OP_LOAD) begin
              // LOAD bypasses the ALU entirely.
              r_acc       <= cmd_data;
              r_c         <= 1'b0;
              r_v         <= 1'b0;
              r_z         <= (cmd_data == 8'h00);
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_alu_a   <= r_acc;
              r_alu_b   <= cmd_data;
              r_alu_sel <= cmd_op;
`ifdef ALU_SEQ_ADC_EN
              r_is_adc  <= (cmd_op == OP_ADC);
              r_orig_a  <= r_acc;
              r_orig_b  <= cmd_data;
              // The ALU has no ADC select; the first pass is a plain ADD.
              if (cmd_op == OP_ADC) begin
                r_alu_sel <= OP_ADD;
              end
`endif
              r_state   <= S_EXEC;
            end
          end
        end

        S_EXEC: begin
`ifdef ALU_SEQ_ADC_EN
          if (r_is_adc) begin
            // Second pass adds the carry that was current before this
            // command; r_c has not been touched yet at this point.
            r_c1      <= alu_carry;
            r_alu_a   <= alu_y;
            r_alu_b   <= {7'b0000000, r_c};
            r_alu_sel <= OP_ADD;
            r_state   <= S_EXEC2;
          end else begin
            r_acc       <= alu_y;
            r_c         <= alu_carry;
            r_v         <= alu_overflow;
            r_z         <= w_y_zero;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
`else
          r_acc       <= alu_y;
          r_c         <= alu_carry;
          r_v         <= alu_overflow;
          r_z         <= w_y_zero;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
`endif
        end

`ifdef ALU_SEQ_ADC_EN
        S_EXEC2: begin
          // At most one of the two passes can carry out, so OR is exact.
          r_acc       <= alu_y;
          r_c         <= r_c1 | alu_carry;
          r_v         <= w_adc_v;
          r_z         <= w_y_zero;
          r_is_adc    <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
`endif

        S_RESP: begin
          // Response data is the accumulator itself, so it is stable for as
          // long as the response is stalled.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_acc   = r_acc;
  assign rsp_flags = {r_c, r_z, r_v};
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for alu_seq_ctrl. Provides a stand-in combinational ALU, a
// transaction-level reference model of accumulator/flags/handshake timing
// that is compared against the DUT every cycle, and directed commands with
// hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_ADC  = 4'b1000;
  localparam logic [3:0] OP_LOAD = 4'b1111;

`ifdef ALU_SEQ_ADC_EN
  localparam bit ADC_EN = 1'b1;
`else
  localparam bit ADC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = 4'h0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_acc;
  logic [2:0] rsp_flags;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_y;
  logic       alu_carry;
  logic       alu_zero;
  logic       alu_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_acc      (rsp_acc),
    .rsp_flags    (rsp_flags),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_y        (alu_y),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow)
  );

  // Stand-in for the team's combinational ALU.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum      = 9'h000;
    alu_y        = 8'h00;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y        = alu_sum[7:0];
        alu_carry    = alu_sum[8];
        alu_overflow = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
      end
      OP_SUB: begin
        alu_y        = alu_a - alu_b;
        alu_carry    = (alu_a < alu_b);
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]);
      end
      OP_AND: alu_y = alu_a & alu_b;
      OP_OR:  alu_y = alu_a | alu_b;
      OP_XOR: alu_y = alu_a ^ alu_b;
      OP_NOT: alu_y = ~alu_a;
      OP_SHL: begin
        alu_y     = {alu_a[6:0], 1'b0};
        alu_carry = alu_a[7];
      end
      OP_SHR: begin
        alu_y     = {1'b0, alu_a[7:1]};
        alu_carry = alu_a[0];
      end
      default: alu_y = 8'h00;
    endcase
    alu_zero = (alu_y == 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result of one command in plain integer arithmetic:
  // returns {carry, zero, overflow, acc}.
  function automatic logic [10:0] model_exec(input logic [3:0] op, input logic [7:0] d,
                                             input logic [7:0] a, input logic cin);
    int         s;
    int         ss;
    logic [7:0] y;
    logic       c;
    logic       v;
    y = 8'h00; c = 1'b0; v = 1'b0; s = 0; ss = 0;
    if (op == OP_LOAD) begin
      y = d;
    end else if (op == OP_ADD) begin
      s  = int'(a) + int'(d);
      ss = int'($signed(a)) + int'($signed(d));
      y  = s[7:0];
      c  = (s > 255);
      v  = (ss > 127) || (ss < -128);
    end else if (op == OP_SUB) begin
      s  = int'(a) - int'(d);
      ss = int'($signed(a)) - int'($signed(d));
      y  = s[7:0];
      c  = (s < 0);
      v  = (ss > 127) || (ss < -128);
    end else if (op == OP_AND) y = a & d;
    else if (op == OP_OR)  y = a | d;
    else if (op == OP_XOR) y = a ^ d;
    else if (op == OP_NOT) y = ~a;
    else if (op == OP_SHL) begin
      s = int'(a) * 2;
      y = s[7:0];
      c = (s > 255);
    end else if (op == OP_SHR) begin
      y = a / 2;
      c = (a % 2) == 1;
    end else if (op == OP_ADC && ADC_EN) begin
      s  = int'(a) + int'(d) + int'(cin);
      ss = int'($signed(a)) + int'($signed(d)) + int'(cin);
      y  = s[7:0];
      c  = (s > 255);
      v  = (ss > 127) || (ss < -128);
    end
    return {c, (y == 8'h00), v, y};
  endfunction

  // Cycles from accept edge to the edge that raises rsp_valid.
  function automatic int model_lat(input logic [3:0] op);
    if (op == OP_LOAD) return 0;
    if (op == OP_ADC && ADC_EN) return 2;
    return 1;
  endfunction

  // Transaction/handshake model, advanced on every rising edge.
  logic        m_started = 1'b0;
  logic        m_ready   = 1'b0;
  logic        m_valid   = 1'b0;
  logic [7:0]  m_acc     = 8'h00;
  logic [2:0]  m_flags   = 3'b000;
  logic [10:0] m_pend    = 11'h000;
  int          m_cnt     = 0;

  always @(posedge clk) begin
    m_started <= 1'b1;
    if (rst) begin
      m_ready <= 1'b0;
      m_valid <= 1'b0;
      m_acc   <= 8'h00;
      m_flags <= 3'b000;
      m_cnt   <= 0;
    end else if (m_ready && cmd_valid) begin
      m_ready <= 1'b0;
      if (model_lat(cmd_op) == 0) begin
        {m_flags, m_acc} <= model_exec(cmd_op, cmd_data, m_acc, m_flags[2]);
        m_valid <= 1'b1;
      end else begin
        m_pend <= model_exec(cmd_op, cmd_data, m_acc, m_flags[2]);
        m_cnt  <= model_lat(cmd_op);
      end
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        {m_flags, m_acc} <= m_pend;
        m_valid <= 1'b1;
      end
    end else if (m_valid) begin
      if (rsp_ready) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
      end
    end else begin
      m_ready <= 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      chk("cyc_cmd_ready", {31'b0, cmd_ready}, {31'b0, m_ready});
      chk("cyc_rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
      chk("cyc_rsp_acc",   {24'b0, rsp_acc},   {24'b0, m_acc});
      chk("cyc_rsp_flags", {29'b0, rsp_flags}, {29'b0, m_flags});
    end
  end

  task automatic send(input logic [3:0] op, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_wait", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string name, input logic [7:0] exp_acc, input logic [2:0] exp_flags,
                         input int exp_lat, input int hold);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_acc"},   {24'b0, rsp_acc},   {24'b0, exp_acc});
    chk({name, "_flags"}, {29'b0, rsp_flags}, {29'b0, exp_flags});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, {31'b0, rsp_valid}, 32'd1);
      chk({name, "_hold_acc"},   {24'b0, rsp_acc},   {24'b0, exp_acc});
      chk({name, "_hold_ready"}, {31'b0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    $display("rsp %s: acc=%02h flags=%03b latency=%0d", name, exp_acc, exp_flags, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 3 cycles.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_alu_a",     {24'b0, alu_a},     32'd0);
    chk("rst_alu_sel",   {28'b0, alu_sel},   32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("post_rst_acc",       {24'b0, rsp_acc},   32'd0);
    chk("post_rst_flags",     {29'b0, rsp_flags}, 32'd0);

    // Signed overflow on ADD.
    send(OP_LOAD, 8'h7F); get_rsp("load_7f", 8'h7F, 3'b000, 1, 0);
    send(OP_ADD,  8'h01); get_rsp("add_ovf", 8'h80, 3'b001, 2, 0);

    // SUB to zero, then borrow.
    send(OP_LOAD, 8'h05); get_rsp("load_05", 8'h05, 3'b000, 1, 0);
    send(OP_SUB,  8'h05); get_rsp("sub_zero", 8'h00, 3'b010, 2, 0);
    send(OP_SUB,  8'h01); get_rsp("sub_borrow", 8'hFF, 3'b100, 2, 0);

    // Response back-pressure for 5 cycles.
    send(OP_LOAD, 8'hAA); get_rsp("load_aa", 8'hAA, 3'b000, 1, 0);
    send(OP_XOR,  8'hAA); get_rsp("xor_stall", 8'h00, 3'b010, 2, 5);

    // Logic and shift ops.
    send(OP_LOAD, 8'hF0); get_rsp("load_f0", 8'hF0, 3'b000, 1, 0);
    send(OP_AND,  8'h3C); get_rsp("and", 8'h30, 3'b000, 2, 0);
    send(OP_OR,   8'h0F); get_rsp("or",  8'h3F, 3'b000, 2, 0);
    send(OP_NOT,  8'h00); get_rsp("not", 8'hC0, 3'b000, 2, 0);
    send(OP_SHL,  8'h00); get_rsp("shl", 8'h80, 3'b100, 2, 0);
    send(OP_SHR,  8'h00); get_rsp("shr", 8'h40, 3'b000, 2, 0);
    send(4'b1001, 8'h55); get_rsp("undef_op", 8'h00, 3'b010, 2, 0);
    send(OP_LOAD, 8'h00); get_rsp("load_00", 8'h00, 3'b010, 1, 0);

    // ADC (or forwarded select 1000 when the feature is off).
    send(OP_LOAD, 8'hFF); get_rsp("load_ff", 8'hFF, 3'b000, 1, 0);
    send(OP_ADD,  8'h01); get_rsp("add_carry", 8'h00, 3'b110, 2, 0);
`ifdef ALU_SEQ_ADC_EN
    send(OP_ADC,  8'h10); get_rsp("adc", 8'h11, 3'b000, 3, 2);
    send(OP_LOAD, 8'h7F); get_rsp("load_7f_b", 8'h7F, 3'b000, 1, 0);
    send(OP_ADC,  8'h00); get_rsp("adc_nocarry", 8'h7F, 3'b000, 3, 0);
`else
    send(OP_ADC,  8'h10); get_rsp("op1000", 8'h00, 3'b010, 2, 0);
`endif

    // Reset in the middle of EXEC drops the command.
    send(OP_LOAD, 8'h33); get_rsp("load_33", 8'h33, 3'b000, 1, 0);
    send(OP_ADD,  8'h01);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_acc",   {24'b0, rsp_acc},   32'd0);
    chk("midrst_ready", {31'b0, cmd_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("midrst_acc_hold", {24'b0, rsp_acc}, 32'd0);
    end
    send(OP_ADD, 8'h05); get_rsp("add_after_rst", 8'h05, 3'b000, 2, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
